// File: rtl/step_ctrl.sv
// step_ctrl: CPU clock generator with free-run, single-step and PC breakpoint control.
//   iClk       single clock, all logic on posedge
//   iRst_n     synchronous active-low reset
//   iMode      1 = free-run request, 0 = halt/single-step
//   iStepBtn   raw asynchronous step push-button, active-high
//   iBrkEn     breakpoint enable
//   iBrkAddr   breakpoint match value for iPC[7:0]
//   iPC        current PC from the processor core
//   oCpuClk    registered processor clock, period DIV iClk cycles
//   oCpuRst_n  processor reset, low only in INIT
//   oState     FSM state (INIT/HALT/RUN/STEP)
//   oBrkHit    sticky breakpoint flag
//   oCycleCnt  count of oCpuClk rising edges, wraps
module step_ctrl #(
   parameter int DIV        = 10,
   parameter int DEB_CYCLES = 16
) (
   input  logic        iClk,
   input  logic        iRst_n,
   input  logic        iMode,
   input  logic        iStepBtn,
   input  logic        iBrkEn,
   input  logic [7:0]  iBrkAddr,
   input  logic [31:0] iPC,
   output logic        oCpuClk,
   output logic        oCpuRst_n,
   output logic [1:0]  oState,
   output logic        oBrkHit,
   output logic [15:0] oCycleCnt
);
   localparam int PW = $clog2(DIV);
   localparam int DW = $clog2(DEB_CYCLES);
   localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
   localparam logic [PW-1:0] PHALF = PW'(DIV / 2);
   localparam logic [DW-1:0] DLAST = DW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {INIT = 2'b00, HALT = 2'b01, RUN = 2'b10, STEP = 2'b11} state_t;

   state_t        state, stateNext;
   logic [1:0]    initCnt;
   logic [PW-1:0] phase, phaseNext;
   logic          sync0, sync1, debLvl, stepPulse;
   logic [DW-1:0] debCnt;
   logic          periodEnd, brkMatch, brkSet, brkClr, clkNext;
   logic          unusedPc;

   assign unusedPc  = ^iPC[31:8];
   assign oState    = state;
   assign oCpuRst_n = state != INIT;

   always_comb begin
      periodEnd = phase == PLAST;
      brkMatch  = iBrkEn && iPC[7:0] == iBrkAddr;
      stateNext = state;
      brkSet    = 1'b0;
      brkClr    = 1'b0;
      case (state)
         INIT: stateNext = (initCnt == 2'd3) ? HALT : INIT;
         HALT: begin
            stateNext = stepPulse ? STEP : (iMode && !oBrkHit) ? RUN : HALT;
            brkClr    = stepPulse || !iMode;
         end
         RUN: begin
            // mode and breakpoint only act on a completed period
            stateNext = (periodEnd && (!iMode || brkMatch)) ? HALT : RUN;
            brkSet    = periodEnd && iMode && brkMatch;
         end
         default: stateNext = periodEnd ? HALT : STEP;
      endcase
      // phase restarts on every state entry and on every period boundary
      phaseNext = ((stateNext == RUN || stateNext == STEP) && stateNext == state && !periodEnd) ? phase + 1'b1 : '0;
      clkNext   = (stateNext == RUN || stateNext == STEP) && phaseNext >= PHALF;
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state     <= INIT;
         initCnt   <= '0;
         phase     <= '0;
         oCpuClk   <= 1'b0;
         oBrkHit   <= 1'b0;
         oCycleCnt <= '0;
         sync0     <= 1'b0;
         sync1     <= 1'b0;
         debLvl    <= 1'b0;
         debCnt    <= '0;
         stepPulse <= 1'b0;
      end else begin
         state     <= stateNext;
         initCnt   <= (state == INIT) ? initCnt + 1'b1 : '0;
         phase     <= phaseNext;
         oCpuClk   <= clkNext;
         oCycleCnt <= oCycleCnt + 16'(clkNext && !oCpuClk);
         oBrkHit   <= brkSet || (oBrkHit && !brkClr);
         sync0     <= iStepBtn;
         sync1     <= sync0;
         // any cycle agreeing with the debounced level restarts the count
         debCnt    <= (sync1 == debLvl || debCnt == DLAST) ? '0 : debCnt + 1'b1;
         debLvl    <= (sync1 != debLvl && debCnt == DLAST) ? sync1 : debLvl;
         stepPulse <= sync1 && !debLvl && debCnt == DLAST;
      end
   end
endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: self-checking bench for step_ctrl with DIV=4, DEB_CYCLES=3.
//   Every cycle compares the DUT against a time-in-state reference model;
//   a vector table and directed sequences add fixed expectations.
module tb_step_ctrl;
   localparam int DIV = 4;
   localparam int DEB = 3;

   logic        iClk = 1'b0, iRst_n = 1'b0, iMode = 1'b0, iStepBtn = 1'b0, iBrkEn = 1'b0;
   logic [7:0]  iBrkAddr = '0;
   logic [31:0] iPC = '0;
   logic        oCpuClk, oCpuRst_n, oBrkHit;
   logic [1:0]  oState;
   logic [15:0] oCycleCnt;

   step_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
      .iClk(iClk), .iRst_n(iRst_n), .iMode(iMode), .iStepBtn(iStepBtn),
      .iBrkEn(iBrkEn), .iBrkAddr(iBrkAddr), .iPC(iPC),
      .oCpuClk(oCpuClk), .oCpuRst_n(oCpuRst_n), .oState(oState),
      .oBrkHit(oBrkHit), .oCycleCnt(oCycleCnt)
   );

   always #5 iClk = ~iClk;

   int nCmp = 0;
   int nBad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // reference model: state plus cycles spent in it, raw button history, debounce window
   int mSt = 0, mT = 0, mCnt = 0;
   bit mBrk = 0, mClk = 0, mDeb = 0, mPulse = 0, autoPc = 0;
   bit bq[$];
   bit win[$];

   task automatic modelStep();
      bit endP, setB, clrB, nClk, sync, allDiff;
      int nSt;
      if (!iRst_n) begin
         mSt = 0; mT = 0; mCnt = 0; mBrk = 0; mClk = 0; mDeb = 0; mPulse = 0;
         bq.delete(); bq.push_back(0); bq.push_back(0);
         win.delete(); repeat (DEB) win.push_back(0);
         return;
      end
      endP = (mT % DIV) == DIV - 1;
      nSt = mSt; setB = 0; clrB = 0;
      if (mSt == 0 && mT == 3) nSt = 1;
      if (mSt == 1) begin
         clrB = mPulse || !iMode;
         nSt = mPulse ? 3 : (iMode && !mBrk) ? 2 : 1;
      end
      if (mSt == 2 && endP && !iMode) nSt = 1;
      else if (mSt == 2 && endP && iBrkEn && iPC[7:0] == iBrkAddr) begin setB = 1; nSt = 1; end
      if (mSt == 3 && endP) nSt = 1;
      mBrk = setB ? 1'b1 : clrB ? 1'b0 : mBrk;
      mT = (nSt == mSt) ? mT + 1 : 0;
      mSt = nSt;
      nClk = (mSt >= 2) && ((mT % DIV) >= DIV / 2);
      if (nClk && !mClk) mCnt = (mCnt + 1) % 65536;
      mClk = nClk;
      sync = bq.pop_front();
      bq.push_back(iStepBtn);
      void'(win.pop_front());
      win.push_back(sync);
      allDiff = 1;
      foreach (win[i]) if (win[i] == mDeb) allDiff = 0;
      mPulse = 0;
      if (allDiff) begin mDeb = !mDeb; mPulse = mDeb; end
   endtask

   task automatic tick();
      bit prev;
      prev = mClk;
      modelStep();
      @(posedge iClk);
      @(negedge iClk);
      chk("mdl_state", oState, mSt);
      chk("mdl_cpuClk", oCpuClk, mClk);
      chk("mdl_cpuRst_n", oCpuRst_n, mSt != 0);
      chk("mdl_brkHit", oBrkHit, mBrk);
      chk("mdl_cycleCnt", oCycleCnt, mCnt);
      if (autoPc && mClk && !prev) iPC = iPC + 4;
   endtask

   typedef struct {
      bit rst, mode, btn;
      int st, clk, crst, cnt;
   } vec_t;

   function automatic vec_t mk(bit r, bit m, bit b, int st, int clk, int crst, int cnt);
      vec_t v;
      v.rst = r; v.mode = m; v.btn = b; v.st = st; v.clk = clk; v.crst = crst; v.cnt = cnt;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[$];
      int n, btnHold;
      repeat (2) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      repeat (3) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      repeat (2) tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0));
      repeat (5) tbl.push_back(mk(1, 0, 1, 1, 0, 1, 0));
      repeat (2) tbl.push_back(mk(1, 0, 1, 3, 0, 1, 0));
      repeat (2) tbl.push_back(mk(1, 0, 1, 3, 1, 1, 1));
      tbl.push_back(mk(1, 0, 1, 1, 0, 1, 1));
      repeat (6) tbl.push_back(mk(1, 0, 0, 1, 0, 1, 1));
      for (int k = 0; k < tbl.size(); k++) begin
         iRst_n = tbl[k].rst; iMode = tbl[k].mode; iStepBtn = tbl[k].btn;
         tick();
         chk($sformatf("tbl%0d_state", k), oState, tbl[k].st);
         chk($sformatf("tbl%0d_cpuClk", k), oCpuClk, tbl[k].clk);
         chk($sformatf("tbl%0d_cpuRst_n", k), oCpuRst_n, tbl[k].crst);
         chk($sformatf("tbl%0d_cycleCnt", k), oCycleCnt, tbl[k].cnt);
      end
      // bounce shorter than the debounce window never steps
      for (int i = 0; i < 14; i++) begin
         iStepBtn = (i < 4) ? ~i[0] : 1'b0;
         tick();
         chk("bounce_state", oState, 1);
         chk("bounce_cnt", oCycleCnt, 1);
      end
      // free run, then drop mode in the high phase
      iMode = 1;
      repeat (39) tick();
      chk("run_cnt", oCycleCnt, 11);
      chk("run_clkhigh", oCpuClk, 1);
      iMode = 0;
      tick();
      chk("run_finish_state", oState, 2);
      chk("run_finish_clk", oCpuClk, 1);
      tick();
      chk("run_halt_state", oState, 1);
      chk("run_halt_clk", oCpuClk, 0);
      chk("run_halt_cnt", oCycleCnt, 11);
      // breakpoint at PC 0x0C
      iBrkEn = 1; iBrkAddr = 8'h0C; iPC = 0; autoPc = 1; iMode = 1;
      tick();
      n = 0;
      while (mSt != 1 && n < 100) begin tick(); n++; end
      chk("brk_timeout", n < 100, 1);
      chk("brk_state", oState, 1);
      chk("brk_hit", oBrkHit, 1);
      chk("brk_pc", iPC[7:0], 8'h0C);
      chk("brk_cnt", oCycleCnt, 14);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("brk_hold_state", oState, 1);
      end
      // step out of the breakpoint, then free run resumes
      iStepBtn = 1;
      repeat (6) tick();
      chk("stepout_state", oState, 3);
      chk("stepout_brk", oBrkHit, 0);
      iStepBtn = 0;
      repeat (4) tick();
      chk("stepout_halt", oState, 1);
      chk("stepout_cnt", oCycleCnt, 15);
      tick();
      chk("resume_state", oState, 2);
      chk("resume_pc", iPC[7:0], 8'h10);
      repeat (8) tick();
      chk("resume_running", oState, 2);
      // reset during a high phase
      n = 0;
      while (!mClk && n < 20) begin tick(); n++; end
      chk("rsthigh_timeout", n < 20, 1);
      iRst_n = 0;
      tick();
      chk("rst_clk", oCpuClk, 0);
      chk("rst_state", oState, 0);
      chk("rst_cnt", oCycleCnt, 0);
      iRst_n = 1;
      repeat (3) tick();
      chk("reinit_rstn", oCpuRst_n, 0);
      tick();
      chk("reinit_halt", oState, 1);
      chk("reinit_rstn_hi", oCpuRst_n, 1);
      // randomized traffic against the model
      btnHold = 0;
      repeat (3000) begin
         iRst_n = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 19) == 0) iMode = ~iMode;
         if (btnHold == 0) begin
            iStepBtn = 1'($urandom_range(0, 1));
            btnHold = $urandom_range(1, 8);
         end
         btnHold--;
         if ($urandom_range(0, 49) == 0) iBrkEn = ~iBrkEn;
         if ($urandom_range(0, 99) == 0) iBrkAddr = iPC[7:0] + 8'(4 * $urandom_range(1, 6));
         if ($urandom_range(0, 199) == 0) iPC = $urandom;
         tick();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
